div_iter_ctrl: RTL and testbench
================================

// Module: div_iter_ctrl
// PURPOSE
//  Multi-cycle integer divider for the PPC execute stage (divw/divwu).
//  Sequences one non-restoring divide step per cycle over a (WIDTH+1)-bit
//  partial remainder, then runs a correction/sign-fixup cycle.
//  Sits between the EX-stage operand muxes and the writeback mux.
//  Stalls the pipeline via busy until the done pulse.
// PARAMETERS
//  WIDTH  32  operand, quotient and remainder width in bits (>=4)
// PORTS
//  clk        in   1      system clock, all state on rising edge
//  rst        in   1      synchronous reset, active-high
//  start      in   1      request; accepted only in IDLE
//  sign       in   1      1 = signed (divw), 0 = unsigned (divwu); sampled with start
//  srcA       in   WIDTH  dividend; sampled with start
//  srcB       in   WIDTH  divisor; sampled with start
//  flush      in   1      abort current op (pipeline flush)
//  busy       out  1      high from the cycle after acceptance until done
//  done       out  1      one-cycle pulse: quotient/remainder/ovf valid
//  quotient   out  WIDTH  result quotient, held until next acceptance
//  remainder  out  WIDTH  result remainder, held until next acceptance
//  ovf        out  1      divide-by-zero or signed overflow, held with results
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, quotient=0, remainder=0, ovf=0,
//   counter=0, all internal registers 0. Reset overrides start and flush.
//  States: IDLE -> CALC -> FIX -> DONE -> IDLE; IDLE -> DONE (ovf path).
//  IDLE: on start (cycle T) latch |srcA|,|srcB| (magnitudes if sign=1,
//   raw if sign=0), negA=sign&srcA[MSB], negB=sign&srcB[MSB].
//   ovf = (srcB==0) | (sign & srcA==MIN_NEG & srcB==all-ones).
//   ovf=1 -> DONE; else -> CALC, counter=WIDTH, rem=0 ((WIDTH+1) bits).
//  CALC: per cycle, shift {rem,dividend} left 1; if rem[WIDTH]==0
//   rem -= {0,divisor} else rem += {0,divisor}; quotient bit shifted in
//   = ~rem_new[WIDTH]. counter decrements; counter==1 -> FIX next.
//   Exactly WIDTH CALC cycles.
//  FIX: if rem[WIDTH]==1, rem += divisor. q = negA^negB ? -q : q;
//   r = negA ? -rem : rem (two's complement, mod 2^WIDTH). -> DONE.
//  DONE: done=1 for this cycle only; outputs updated on entry; -> IDLE.
//   ovf path: quotient=0, remainder=0, ovf=1.
//  Latency: normal done at T+WIDTH+2; ovf done at T+1.
//  busy=1 in CALC, FIX, DONE; 0 in IDLE. start while busy is ignored
//   (no queueing). start in same cycle as done is ignored; next start
//   accepted in IDLE (back-to-back throughput one op per WIDTH+3 cycles).
//  flush: in any non-IDLE state -> IDLE next cycle, no done pulse,
//   quotient/remainder/ovf keep previous values. flush in IDLE with start:
//   start ignored. flush coincident with DONE: done still pulses.
//  Operand registers are internal; srcA/srcB may change after acceptance.
//  Zero dividend: normal path, quotient=0, remainder=0, ovf=0.
// TESTING  (WIDTH=32)
//  1 unsigned 100/7 start@T -> done@T+34, q=14, r=2, ovf=0; busy T+1..T+34.
//  2 signed -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF; 7/-2 -> q=0xFFFFFFFD, r=1.
//  3 x/0 (any sign) and signed 0x80000000/0xFFFFFFFF -> done@T+1, q=0,
//    r=0, ovf=1; unsigned 0x80000000/0xFFFFFFFF -> q=0, r=0x80000000, ovf=0.
//  4 start pulses at T+5, T+20 while busy -> ignored, single done@T+34,
//    result from first operands; start@T+34 ignored, start@T+35 accepted.
//  5 flush@T+10 -> IDLE@T+11, no done, outputs hold prior result; new
//    start@T+11 completes normally@T+45.
//  6 rst@T+10 mid-op -> all outputs 0 next cycle; 0xFFFFFFFF/1 unsigned
//    afterwards -> q=0xFFFFFFFF, r=0; random signed/unsigned vs model.

Source files
------------

// File: rtl/div_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_iter_ctrl
// Description : Multi-cycle integer divider for the execute stage (divw and
//               divwu). Operands are converted to magnitudes on acceptance.
//               One non-restoring divide step runs per cycle over a
//               (WIDTH+1)-bit partial remainder. A final cycle then corrects
//               the remainder and applies the result signs. busy stalls the
//               pipeline until the single-cycle done pulse.
// Ports       :
//   clk        in   1      system clock, rising edge
//   rst        in   1      synchronous reset, active-high
//   start      in   1      request, accepted only in IDLE
//   sign       in   1      1 = signed (divw), 0 = unsigned (divwu)
//   srcA       in   WIDTH  dividend, sampled with start
//   srcB       in   WIDTH  divisor, sampled with start
//   flush      in   1      abort the operation in flight
//   busy       out  1      operation in flight (CALC, FIX or DONE)
//   done       out  1      one-cycle pulse, results valid
//   quotient   out  WIDTH  quotient, held until the next result
//   remainder  out  WIDTH  remainder, held until the next result
//   ovf        out  1      divide-by-zero or signed overflow
// Revision    : 1.0  initial release
// ============================================================================
module div_iter_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;

    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   rem;      // signed partial remainder
    logic [WIDTH-1:0] dvd_q;    // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvs;      // divisor magnitude
    logic             neg_a;
    logic             neg_b;

    // ------------------------------------------------------------------
    // Operand qualification in IDLE
    // ------------------------------------------------------------------
    logic             in_neg_a;
    logic             in_neg_b;
    logic [WIDTH-1:0] in_mag_a;
    logic [WIDTH-1:0] in_mag_b;
    logic             in_ovf;
    logic             accept;

    assign in_neg_a = sign & srcA[WIDTH-1];
    assign in_neg_b = sign & srcB[WIDTH-1];
    // The magnitude of MIN_NEG wraps back to MIN_NEG. Read as unsigned,
    // this is the correct magnitude.
    assign in_mag_a = in_neg_a ? (~srcA + 1'b1) : srcA;
    assign in_mag_b = in_neg_b ? (~srcB + 1'b1) : srcB;
    assign in_ovf   = (srcB == '0) | (sign & (srcA == MIN_NEG) & (srcB == ALL_ONE));
    assign accept   = (state == S_IDLE) & start & ~flush;

    // ------------------------------------------------------------------
    // Non-restoring step
    // The sign of the old remainder selects subtract or add. The shifted
    // value can leave the (WIDTH+1)-bit range. The add/sub result always
    // lies in [-dvs, dvs), so the modular arithmetic stays exact.
    // ------------------------------------------------------------------
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] rem_step;

    assign rem_sh   = {rem[WIDTH-1:0], dvd_q[WIDTH-1]};
    assign rem_step = rem[WIDTH] ? (rem_sh + {1'b0, dvs}) : (rem_sh - {1'b0, dvs});

    // ------------------------------------------------------------------
    // Correction and sign fixup
    // The quotient bits from the step loop are already exact. Only a
    // negative final remainder needs the divisor added back.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] rem_mag;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign rem_mag = rem[WIDTH] ? (rem[WIDTH-1:0] + dvs) : rem[WIDTH-1:0];
    assign q_fix   = (neg_a ^ neg_b) ? (~dvd_q + 1'b1) : dvd_q;
    assign r_fix   = neg_a ? (~rem_mag + 1'b1) : rem_mag;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next state and status outputs
    // flush aborts CALC and FIX. DONE always returns to IDLE, so a
    // coincident flush does not suppress the pulse.
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start && !flush) begin
                    state_nx = in_ovf ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_nx = S_IDLE;
                end else if (count == CNT_W'(1)) begin
                    state_nx = S_FIX;
                end
            end
            S_FIX: begin
                state_nx = flush ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            rem   <= '0;
            dvd_q <= '0;
            dvs   <= '0;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
        end else if (accept) begin
            count <= CNT_W'(WIDTH);
            rem   <= '0;
            dvd_q <= in_mag_a;
            dvs   <= in_mag_b;
            neg_a <= in_neg_a;
            neg_b <= in_neg_b;
        end else if (state == S_CALC && !flush) begin
            count <= count - 1'b1;
            rem   <= rem_step;
            dvd_q <= {dvd_q[WIDTH-2:0], ~rem_step[WIDTH]};
        end
    end

    // ------------------------------------------------------------------
    // Result registers. They load only when DONE is entered, so an
    // aborted operation leaves the previous result visible.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
        end else if (accept && in_ovf) begin
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b1;
        end else if (state == S_FIX && !flush) begin
            quotient  <= q_fix;
            remainder <= r_fix;
            ovf       <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_iter_ctrl
// Description : Self-checking bench for div_iter_ctrl at WIDTH=32. Covers
//               directed, corner-case and random operations against a
//               plain-arithmetic reference. Also covers flush, reset and
//               start-while-busy behaviour.
// Revision    : 1.0  initial release
// ============================================================================
module tb_div_iter_ctrl;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             sign;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             ovf;

    int total = 0;
    int bad   = 0;

    div_iter_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sign      (sign),
        .srcA      (srcA),
        .srcB      (srcB),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: overflow rules first, then SV integer division.
    // Signed SV division truncates toward zero, and the remainder takes the
    // sign of the dividend.
    function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic o);
        int sa;
        int sb;
        if (b == 32'd0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
            q = 32'd0;
            r = 32'd0;
            o = 1'b1;
        end else if (s) begin
            sa = a;
            sb = b;
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
            o  = 1'b0;
        end else begin
            q = a / b;
            r = a % b;
            o = 1'b0;
        end
    endfunction

    // Presents the operands for one cycle, then scrambles them. Returns at
    // the negedge of the first cycle after acceptance.
    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        sign  = s;
        srcA  = a;
        srcB  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sign  = 1'($urandom);
        srcA  = $urandom;
        srcB  = $urandom;
    endtask

    // lat counts cycles after acceptance. busy must be high in every one of
    // those cycles, including the done cycle.
    task automatic wait_done(output int lat, output int berr);
        lat  = 1;
        berr = 0;
        while (!done && lat < 200) begin
            if (busy !== 1'b1) berr++;
            @(negedge clk);
            lat++;
        end
        if (busy !== 1'b1) berr++;
        chk("done_seen", 32'(done), 32'd1);
    endtask

    task automatic run_check(input logic s, input logic [31:0] a, input logic [31:0] b);
        int lat;
        int berr;
        logic [31:0] eq;
        logic [31:0] er;
        logic        eo;
        model(s, a, b, eq, er, eo);
        launch(s, a, b);
        wait_done(lat, berr);
        chk("latency", 32'(lat), eo ? 32'd1 : 32'(LAT));
        chk("busy_run", 32'(berr), 32'd0);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("ovf", 32'(ovf), 32'(eo));
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
    endtask

    logic [31:0] ra;
    logic [31:0] rb;

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0:       return 32'($urandom_range(0, 15));
            1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            2:       return 32'($urandom_range(0, 1000));
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        int lat;
        int berr;
        int seen_done;

        rst   = 1'b1;
        start = 1'b0;
        sign  = 1'b0;
        srcA  = '0;
        srcB  = '0;
        flush = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);

        // Directed operations
        run_check(1'b0, 32'd100, 32'd7);
        run_check(1'b1, -32'sd7, 32'd2);
        run_check(1'b1, 32'd7, -32'sd2);
        run_check(1'b0, 32'd5, 32'd0);
        run_check(1'b1, -32'sd5, 32'd0);
        run_check(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_check(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_check(1'b1, 32'd0, 32'd9);
        run_check(1'b0, 32'hFFFF_FFFF, 32'd1);
        run_check(1'b1, 32'h8000_0000, 32'd1);
        run_check(1'b1, 32'h8000_0000, 32'd2);
        run_check(1'b1, -32'sd100, -32'sd7);

        // Start pulses while busy are ignored
        launch(1'b0, 32'd1000, 32'd3);
        n    = 1;
        berr = 0;
        while (!done && n < 200) begin
            if (busy !== 1'b1) berr++;
            start = (n == 5 || n == 20);
            srcA  = 32'd7;
            srcB  = 32'd1;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("ign_latency", 32'(n), 32'(LAT));
        chk("ign_busy", 32'(berr), 32'd0);
        chk("ign_quotient", quotient, 32'd333);
        chk("ign_remainder", remainder, 32'd1);
        // Start during done is dropped; held into IDLE, it is accepted
        sign  = 1'b0;
        srcA  = 32'd50;
        srcB  = 32'd5;
        start = 1'b1;
        @(negedge clk);
        chk("start_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("start_after_done", 32'(busy), 32'd1);
        wait_done(lat, berr);
        chk("b2b_latency", 32'(lat), 32'(LAT));
        chk("b2b_quotient", quotient, 32'd10);
        chk("b2b_remainder", remainder, 32'd0);

        // Flush mid-operation
        run_check(1'b0, 32'd100, 32'd7);
        launch(1'b1, -32'sd50, 32'd3);
        n         = 1;
        seen_done = 0;
        while (n < 10) begin
            if (done) seen_done++;
            @(negedge clk);
            n++;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_done", 32'(seen_done + int'(done)), 32'd0);
        chk("flush_quotient", quotient, 32'd14);
        chk("flush_remainder", remainder, 32'd2);
        chk("flush_ovf", 32'(ovf), 32'd0);
        sign  = 1'b0;
        srcA  = 32'd200;
        srcB  = 32'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, berr);
        chk("post_flush_latency", 32'(lat), 32'(LAT));
        chk("post_flush_quotient", quotient, 32'd22);
        chk("post_flush_remainder", remainder, 32'd2);

        // Flush with start in IDLE: start is dropped
        @(negedge clk);
        srcA  = 32'd9;
        srcB  = 32'd3;
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        chk("idle_flush_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("idle_flush_done", 32'(done), 32'd0);

        // Flush coincident with done: the pulse still occurs
        launch(1'b0, 32'd77, 32'd5);
        wait_done(lat, berr);
        flush = 1'b1;
        #1;
        chk("flush_at_done", 32'(done), 32'd1);
        chk("flush_at_done_q", quotient, 32'd15);
        chk("flush_at_done_r", remainder, 32'd2);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_at_done_idle", 32'(busy), 32'd0);

        // Reset in the middle of an operation
        launch(1'b1, -32'sd1000, 32'd7);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_quotient", quotient, 32'd0);
        chk("mid_rst_remainder", remainder, 32'd0);
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
        run_check(1'b0, 32'hFFFF_FFFF, 32'd1);

        // Random operations
        for (int i = 0; i < 60; i++) begin
            ra = pick();
            rb = pick();
            run_check(1'($urandom), ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
